ram_stream_reader: RTL and testbench

- Read-side consumer for the 4Kx8 dual-port sync RAMs used throughout the SoC.
- On a start command, issues sequential reads on the RAM's registered-address read port (rce/radr/o, one-cycle latency) from a base address for a given byte count.
- Delivers the bytes as a valid/ready stream with last-byte marking and a done pulse.
- Sits between a frame/packet buffer RAM and a byte-serial consumer such as a UART TX, video fetch or DMA.

---
 rtl/ram_stream_reader.sv | 102 ++++++++++
 tb/tb_ram_stream_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams len bytes from a sync-read RAM starting at base as a valid/ready byte stream
module ram_stream_reader #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int FD = 3
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          ram_rce,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_o,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last
);
  localparam int PW = FD > 1 ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0] issue_q, issue_d, deliv_q, deliv_d, len_c;
  logic infl_q, infl_d, done_q, done_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [FD];
  logic pop, flush;
  assign len_c = len > (AW+1)'(1 << AW) ? (AW+1)'(1 << AW) : len;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign ram_radr = addr_q;
  assign ram_rce = state_q == FETCH && issue_q != '0 && int'(cnt_q) + int'(infl_q) < FD;
  assign dout_valid = cnt_q != '0;
  assign dout = dout_valid ? mem_q[rd_q] : '0;
  assign dout_last = dout_valid && deliv_q == (AW+1)'(1);
  assign pop = dout_valid && dout_ready;
  assign flush = busy && abort;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    issue_d = issue_q;
    deliv_d = deliv_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = len_c != '0 ? FETCH : IDLE;
      addr_d = base;
      issue_d = len_c;
      deliv_d = len_c;
      done_d = len_c == '0;
    end
    if (ram_rce) begin
      addr_d = addr_q + 1'b1;
      issue_d = issue_q - 1'b1;
      state_d = issue_q == (AW+1)'(1) ? DRAIN : FETCH;
    end
    if (pop) begin
      deliv_d = deliv_q - 1'b1;
      if (deliv_q == (AW+1)'(1)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
    if (flush) begin
      state_d = IDLE;
      done_d = 1'b0;
    end
    infl_d = ram_rce && !flush;
    cnt_d = flush ? '0 : cnt_q + CW'(infl_q) - CW'(pop);
    rd_d = flush ? '0 : pop ? (rd_q == PW'(FD - 1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d = flush ? '0 : infl_q ? (wr_q == PW'(FD - 1) ? '0 : wr_q + 1'b1) : wr_q;
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      addr_q <= '0;
      issue_q <= '0;
      deliv_q <= '0;
      infl_q <= 1'b0;
      done_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      issue_q <= issue_d;
      deliv_q <= deliv_d;
      infl_q <= infl_d;
      done_q <= done_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      if (infl_q) mem_q[wr_q] <= ram_o;
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized self-checking bench for ram_stream_reader against a queue-based stream model
module tb_ram_stream_reader;
  logic rclk = 0, rrst = 1, start = 0, abort = 0, dout_ready = 0;
  logic rnd = 0, fixed_ready = 1;
  logic [11:0] base = 0;
  logic [12:0] len = 0;
  logic busy, done, ram_rce, dout_valid, dout_last;
  logic [11:0] ram_radr;
  logic [7:0] ram_o = 0, dout;
  logic [7:0] ram [4096];
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [11:0] adr_q[$];
  int rce_cnt = 0, done_cnt = 0, last_cnt = 0, outst = 0, cur_n = 0;
  logic [11:0] cur_base = 0;
  logic prev_v = 0, prev_r = 0, prev_lhs = 0;
  logic [7:0] prev_d = 0;
  ram_stream_reader dut (
    .rclk(rclk), .rrst(rrst), .start(start), .base(base), .len(len), .abort(abort),
    .busy(busy), .done(done), .ram_rce(ram_rce), .ram_radr(ram_radr), .ram_o(ram_o),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last)
  );
  always #5 rclk = ~rclk;
  always @(posedge rclk) if (ram_rce) ram_o <= ram[ram_radr];
  always @(posedge rclk) begin
    #2;
    dout_ready = rnd ? 1'($urandom_range(0, 1)) : fixed_ready;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge rclk);
    #1;
  endtask
  always @(negedge rclk) begin
    chk("rce_idle", ram_rce & ~busy, 0);
    if (ram_rce) begin
      rce_cnt++;
      outst++;
      adr_q.push_back(ram_radr);
      chk("credit", outst <= 3, 1);
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", busy, 0);
    end
    if (prev_lhs) chk("done_after_last", done, 1);
    if (dout_valid && prev_v && !prev_r) chk("hold", dout, prev_d);
    if (dout_valid && dout_ready) begin
      outst--;
      if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
      else begin
        chk("data", dout, exp_q.pop_front());
        chk("last", dout_last, exp_q.size() == 0);
        if (dout_last) last_cnt++;
      end
    end
    prev_lhs = dout_valid && dout_ready && dout_last;
    prev_v = dout_valid;
    prev_r = dout_ready;
    prev_d = dout;
  end
  task automatic start_xfer(input logic [11:0] b, input logic [12:0] l);
    exp_q.delete();
    adr_q.delete();
    rce_cnt = 0;
    done_cnt = 0;
    last_cnt = 0;
    outst = 0;
    cur_base = b;
    cur_n = l > 4096 ? 4096 : int'(l);
    for (int i = 0; i < cur_n; i++) exp_q.push_back(ram[(int'(b) + i) % 4096]);
    base = b;
    len = l;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input int max);
    int c = 0;
    while (done_cnt == 0 && c < max) begin
      tick();
      c++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (3) tick();
    chk("done_once", done_cnt, 1);
    chk("last_once", last_cnt, 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("rce_total", rce_cnt, cur_n);
    chk("busy_end", busy, 0);
    chk("adr_cnt", adr_q.size(), cur_n);
    for (int i = 0; i < adr_q.size() && i < cur_n; i++) chk("adr", adr_q[i], (int'(cur_base) + i) % 4096);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rce", ram_rce, 0);
    chk("rst_radr", ram_radr, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_dout", dout, 0);
    tick();
    rrst = 0;
    tick();
    fixed_ready = 1;
    tick();
    start_xfer(12'h010, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge rclk);
      chk("lat_rce", ram_rce, c <= 4);
      if (c <= 4) chk("lat_radr", ram_radr, 12'h010 + c - 1);
      chk("lat_valid", dout_valid, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) chk("lat_dout", dout, 8'h10 + c - 3);
      chk("lat_last", dout_last, c == 6);
      chk("lat_done", done, c == 7);
    end
    tick();
    wait_done(20);
    start_xfer(12'hFFE, 4);
    wait_done(50);
    fixed_ready = 0;
    tick();
    tick();
    start_xfer(12'h010, 8);
    for (int c = 0; c < 10 && !dout_valid; c++) @(negedge rclk);
    chk("bp_valid", dout_valid, 1);
    repeat (10) begin
      @(negedge rclk);
      chk("bp_dout", dout, 8'h10);
      chk("bp_valid_hold", dout_valid, 1);
    end
    chk("bp_issued", rce_cnt <= 4, 1);
    tick();
    fixed_ready = 1;
    wait_done(100);
    rnd = 1;
    for (int t = 0; t < 6; t++) begin
      start_xfer(12'($urandom_range(0, 4095)), 13'($urandom_range(2, 40)));
      if (t == 2) begin
        tick();
        base = 12'h555;
        len = 5;
        start = 1;
        tick();
        start = 0;
      end
      wait_done(400);
    end
    start_xfer(12'h123, 4096);
    wait_done(20000);
    rnd = 0;
    tick();
    tick();
    start_xfer(12'($urandom_range(0, 4095)), 13'd6000);
    wait_done(6000);
    start_xfer(12'h030, 0);
    @(negedge rclk);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_rce", ram_rce, 0);
    chk("z_valid", dout_valid, 0);
    @(negedge rclk);
    chk("z_done_pulse", done, 0);
    chk("z_rce2", rce_cnt, 0);
    tick();
    start_xfer(12'h040, 16);
    repeat (4) tick();
    abort = 1;
    tick();
    abort = 0;
    @(negedge rclk);
    chk("ab_busy", busy, 0);
    chk("ab_valid", dout_valid, 0);
    chk("ab_rce", ram_rce, 0);
    repeat (3) @(negedge rclk);
    chk("ab_nodone", done_cnt, 0);
    chk("ab_idle_valid", dout_valid, 0);
    tick();
    abort = 1;
    start_xfer(12'h020, 2);
    abort = 0;
    wait_done(20);
    start_xfer(12'h040, 16);
    repeat (5) tick();
    rrst = 1;
    tick();
    rrst = 0;
    @(negedge rclk);
    chk("rr_busy", busy, 0);
    chk("rr_valid", dout_valid, 0);
    chk("rr_rce", ram_rce, 0);
    chk("rr_dout", dout, 0);
    repeat (3) @(negedge rclk);
    chk("rr_nodone", done_cnt, 0);
    tick();
    start_xfer(12'h020, 2);
    wait_done(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
